vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- CLK_DIV, 2, clk cycles per pixel.
- H_VIS, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal pixel counts.
- V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical line counts.
- SYNC_NEG, 1: 1 = sync pulses active-low.
- FCW, 16: frame counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- pix_en, out, 1: one-clk pixel strobe.
- hpos, out, 10: current pixel column.
- vpos, out, 10: current line.
- hsync, out, 1: horizontal sync.
- vsync, out, 1: vertical sync.
- display_on, out, 1: position is in the visible area.
- line_start, out, 1: one-clk pulse at start of line.
- frame_start, out, 1: one-clk pulse at start of frame.
- frame_cnt, out, FCW: completed-frame count.
REQ-003 H_TOTAL SHALL be H_VIS+H_FP+H_SYNC+H_BP (800) and V_TOTAL SHALL be V_VIS+V_FP+V_SYNC+V_BP (525); both SHALL be <= 1024.

Function
REQ-004 Divider: a counter div SHALL run 0..CLK_DIV-1 and wrap; pix_en=1 exactly when div==CLK_DIV-1. With CLK_DIV=1, pix_en SHALL be 1 on every non-reset cycle.
REQ-005 hpos SHALL increment only on clk edges where pix_en=1, wrapping H_TOTAL-1 -> 0.
REQ-006 vpos SHALL increment on the same edge that hpos wraps, wrapping V_TOTAL-1 -> 0; vpos SHALL be unchanged otherwise.
REQ-007 frame_cnt SHALL increment (mod 2^FCW) on the edge where hpos and vpos both wrap to 0; it SHALL NOT increment on reset release.
REQ-008 hsync, vsync and display_on SHALL be registered and always consistent with the hpos/vpos presented in the same cycle: they are decoded from next-state counter values, giving zero skew.
REQ-009 hsync SHALL be active (0 if SYNC_NEG, else 1) iff H_VIS+H_FP <= hpos < H_VIS+H_FP+H_SYNC (656..751).
REQ-010 vsync SHALL be active iff V_VIS+V_FP <= vpos < V_VIS+V_FP+V_SYNC (490..491); it is independent of hpos.
REQ-011 display_on SHALL be 1 iff hpos<H_VIS and vpos<V_VIS.
REQ-012 line_start SHALL be 1 for one clk iff pix_en=1 and hpos==0.
REQ-013 frame_start SHALL be 1 for one clk iff pix_en=1, hpos==0 and vpos==0.
REQ-014 The pixel at (0,0) after reset release SHALL produce line_start and frame_start on its first pix_en.
REQ-015 Counter arithmetic SHALL compare against terminal counts exactly; no out-of-range hpos/vpos value SHALL ever appear.

Reset
REQ-016 While reset=0 at a clk edge, the registered state SHALL become: div=0, hpos=0, vpos=0, frame_cnt=0, pix_en=0, line_start=0, frame_start=0, display_on=0, hsync and vsync inactive.
REQ-017 Reset SHALL take effect on the next edge from any state, mid-line or mid-frame, with no partial line completing.
REQ-018 On the first cycle after release, display_on SHALL be 1, consistent with (0,0).

Verification
REQ-019 Reset release, CLK_DIV=2 -> pix_en first high on the 2nd clk after release with hpos=0, line_start=frame_start=1; hpos=1 at the next pix_en.
REQ-020 One full line -> hsync low for exactly 96 pix_en periods, first at hpos=656; line_start period = 1600 clk.
REQ-021 One full frame -> vsync low for vpos 490..491 (1600 pix_en); frame_start period = 840000 clk; frame_cnt 0 -> 1.
REQ-022 Count display_on over one frame -> exactly 307200 pix_en cycles; display_on=0 at hpos=640 and at vpos=480.
REQ-023 reset=0 asserted at hpos=400, vpos=300 -> next cycle hpos=vpos=0, frame_cnt=0, hsync=vsync=1, no pulses.
REQ-024 Reduced params (H 4/1/1/1, V 3/1/1/1, FCW=2, CLK_DIV=1) -> frame_cnt sequence 0,1,2,3,0 every 42 clk; frame_start coincides with each increment.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel strobe, h/v counters, sync pulses and frame counter.
// Latency: every output is registered and matches the hpos/vpos shown in the same cycle.
// Backpressure: none; the generator runs freely after reset.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_NEG = 1,
    parameter int FCW      = 16
) (
    input  logic           clk,
    input  logic           reset,
    output logic           pix_en,
    output logic [9:0]     hpos,
    output logic [9:0]     vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] H_SS    = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE    = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SS    = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE    = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic       SYNC_IDLE = (SYNC_NEG != 0);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic          pix_en_nxt;
    logic [9:0]    hpos_nxt;
    logic [9:0]    vpos_nxt;
    logic          h_wrap;
    logic          v_wrap;

    // Next-state counters; all decoded outputs below are derived from these so
    // they line up with the registered hpos/vpos without skew.
    always_comb begin
        div_nxt    = (div == DIV_MAX) ? '0 : div + 1'b1;
        pix_en_nxt = (div_nxt == DIV_MAX);
        h_wrap     = pix_en && (hpos == H_MAX);
        v_wrap     = (vpos == V_MAX);
        hpos_nxt   = hpos;
        vpos_nxt   = vpos;
        if (pix_en) begin
            hpos_nxt = h_wrap ? 10'd0 : hpos + 10'd1;
            if (h_wrap) begin
                vpos_nxt = v_wrap ? 10'd0 : vpos + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hpos        <= 10'd0;
            vpos        <= 10'd0;
            frame_cnt   <= '0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_en      <= pix_en_nxt;
            hpos        <= hpos_nxt;
            vpos        <= vpos_nxt;
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            hsync       <= ((hpos_nxt >= H_SS) && (hpos_nxt < H_SE)) ^ SYNC_IDLE;
            vsync       <= ((vpos_nxt >= V_SS) && (vpos_nxt < V_SE)) ^ SYNC_IDLE;
            display_on  <= (hpos_nxt < H_VIS_L) && (vpos_nxt < V_VIS_L);
            line_start  <= pix_en_nxt && (hpos_nxt == 10'd0);
            frame_start <= pix_en_nxt && (hpos_nxt == 10'd0) && (vpos_nxt == 10'd0);
        end
    end
endmodule
